// File: rtl/count_pulse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_pulse_pkg
// Description : Shared definitions for the count pulse generator. Holds the
//               FSM state encoding and the counter-width helper used to size
//               the debounce and repeat tick counters.
// Revision    : 1.0 - initial release
// ============================================================================
package count_pulse_pkg;

    // FSM state encoding for the pulse generator.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } state_t;

    // Counter width able to hold any value up to max_val. The extra bit keeps
    // the terminal value representable even when max_val is a power of two.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage : count_pulse_pkg
`default_nettype wire

// File: rtl/debounce_filter.sv
`default_nettype none
// ============================================================================
// Module      : debounce_filter
// Description : Two-flop synchroniser followed by a stability counter and a
//               rising-edge detector for one pushbutton input.
// Ports       : clk     - system clock
//               reset   - synchronous, active-high reset
//               btn_raw - asynchronous raw button level, active-high
//               level   - debounced button level
//               press   - high for one cycle after level rises
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_filter
    import count_pulse_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int              c_cnt_w    = cnt_width(DEB_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_d;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // The counter only runs while the synchronised input disagrees
            // with the accepted level; any agreement restarts the window, so
            // the level flips only after DEB_CYCLES consecutive disagreements.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign press = r_level & ~r_level_d;

endmodule : debounce_filter
`default_nettype wire

// File: rtl/count_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : count_pulse_gen
// Description : Converts raw up/down pushbutton levels into single-cycle
//               count pulses with a direction level, including optional
//               hold-to-repeat and a lockout when both buttons are held.
// Ports       : clk          - system clock
//               reset        - synchronous, active-high reset
//               btn_up_raw   - asynchronous raw up button, active-high
//               btn_down_raw - asynchronous raw down button, active-high
//               repeat_en    - enables auto-repeat while a button is held
//               inc          - one-cycle count pulse, registered
//               up_down_sel  - direction (0 = up, 1 = down), registered
//               btn_lock     - high while the lockout state is active
// Revision    : 1.0 - initial release
// ============================================================================
module count_pulse_gen
    import count_pulse_pkg::*;
#(
    parameter int DEB_CYCLES    = 16,
    parameter int REPEAT_DELAY  = 64,
    parameter int REPEAT_PERIOD = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    input  logic repeat_en,
    output logic inc,
    output logic up_down_sel,
    output logic btn_lock
);

    localparam int c_tick_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                               : REPEAT_PERIOD;
    localparam int c_tick_w   = cnt_width(c_tick_max);
    localparam logic [c_tick_w-1:0] c_delay_last  = c_tick_w'(REPEAT_DELAY - 1);
    localparam logic [c_tick_w-1:0] c_period_last = c_tick_w'(REPEAT_PERIOD - 1);

    // ------------------------------------------------------------------
    // Per-button conditioning
    // ------------------------------------------------------------------
    logic w_lvl_up;
    logic w_lvl_dn;
    logic w_press_up;
    logic w_press_dn;

    debounce_filter #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_up (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_up_raw),
        .level   (w_lvl_up),
        .press   (w_press_up)
    );

    debounce_filter #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_dn (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_down_raw),
        .level   (w_lvl_dn),
        .press   (w_press_dn)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_tick_w-1:0] r_tick;
    logic [c_tick_w-1:0] w_tick_nxt;
    logic                r_inc;
    logic                w_inc_nxt;
    logic                r_dir;
    logic                w_dir_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_tick  <= '0;
            r_inc   <= 1'b0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_inc   <= w_inc_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    // The registered direction remembers which button started the hold, so
    // it also selects which debounced level counts as "held" and which one
    // as "the other button".
    logic w_held;
    logic w_other;

    assign w_held  = r_dir ? w_lvl_dn : w_lvl_up;
    assign w_other = r_dir ? w_lvl_up : w_lvl_dn;

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_inc_nxt   = 1'b0;
        w_dir_nxt   = r_dir;

        case (r_state)
            IDLE: begin
                // Both levels high wins over a press event: simultaneous
                // presses and a press on top of a held button both lock out.
                if (w_lvl_up && w_lvl_dn) begin
                    w_state_nxt = LOCK;
                end else if (w_press_up ^ w_press_dn) begin
                    w_inc_nxt   = 1'b1;
                    w_dir_nxt   = w_press_dn;
                    w_tick_nxt  = '0;
                    w_state_nxt = DELAY;
                end
            end

            DELAY: begin
                if (!w_held) begin
                    w_tick_nxt  = '0;
                    w_state_nxt = IDLE;
                end else if (w_other) begin
                    w_tick_nxt  = '0;
                    w_state_nxt = LOCK;
                end else if (r_tick == c_delay_last) begin
                    // Without repeat enabled the tick parks at its terminal
                    // value, so enabling repeat later fires on the next cycle.
                    if (repeat_en) begin
                        w_inc_nxt   = 1'b1;
                        w_tick_nxt  = '0;
                        w_state_nxt = REPEAT;
                    end
                end else begin
                    w_tick_nxt = r_tick + 1'b1;
                end
            end

            REPEAT: begin
                if (!w_held) begin
                    w_tick_nxt  = '0;
                    w_state_nxt = IDLE;
                end else if (w_other) begin
                    w_tick_nxt  = '0;
                    w_state_nxt = LOCK;
                end else if (!repeat_en) begin
                    w_tick_nxt  = c_delay_last;
                    w_state_nxt = DELAY;
                end else if (r_tick == c_period_last) begin
                    w_inc_nxt  = 1'b1;
                    w_tick_nxt = '0;
                end else begin
                    w_tick_nxt = r_tick + 1'b1;
                end
            end

            LOCK: begin
                if (!w_lvl_up && !w_lvl_dn) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_tick_nxt  = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign inc         = r_inc;
    assign up_down_sel = r_dir;
    assign btn_lock    = (r_state == LOCK);

endmodule : count_pulse_gen
`default_nettype wire

// File: tb/tb_count_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_pulse_gen
// Description : Directed self-checking bench for count_pulse_gen with
//               DEB_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4. Inputs change
//               1 time unit after a rising edge; outputs are checked at that
//               same point, so loop index k is the edge count since the input
//               change (first press pulse expected at k = 7).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_pulse_gen;

    logic clk = 1'b0;
    logic reset;
    logic btn_up_raw;
    logic btn_down_raw;
    logic repeat_en;
    logic inc;
    logic up_down_sel;
    logic btn_lock;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    count_pulse_gen #(
        .DEB_CYCLES    (4),
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_up_raw   (btn_up_raw),
        .btn_down_raw (btn_down_raw),
        .repeat_en    (repeat_en),
        .inc          (inc),
        .up_down_sel  (up_down_sel),
        .btn_lock     (btn_lock)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b1;
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;
        repeat_en    = 1'b0;
        settle(3);
        chk("rst_inc", inc, 1'b0);
        chk("rst_dir", up_down_sel, 1'b0);
        chk("rst_lock", btn_lock, 1'b0);
        reset = 1'b0;
        settle(3);
        chk("idle_inc", inc, 1'b0);

        // 1: up held 6 cycles, repeat disabled -> single pulse at edge 7
        btn_up_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("t1_inc_e%0d", k), inc, (k == 7));
            if (k == 7) chk("t1_dir", up_down_sel, 1'b0);
            if (k == 6) btn_up_raw = 1'b0;
        end
        chk("t1_lock", btn_lock, 1'b0);

        // 2a: 3-cycle glitch on down -> rejected
        btn_down_raw = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            chk($sformatf("t2a_inc_e%0d", k), inc, 1'b0);
            if (k == 3) btn_down_raw = 1'b0;
        end

        // 2b: 4-cycle pulse on down -> one down pulse at edge 7
        btn_down_raw = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("t2b_inc_e%0d", k), inc, (k == 7));
            if (k == 6) chk("t2b_dir_before", up_down_sel, 1'b0);
            if (k == 7) chk("t2b_dir_pulse", up_down_sel, 1'b1);
            if (k == 4) btn_down_raw = 1'b0;
        end
        chk("t2b_dir_hold", up_down_sel, 1'b1);

        // 3: repeat enabled, up held 30 cycles -> 7, 15, 19, 23, 27, 31, 35
        repeat_en  = 1'b1;
        btn_up_raw = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            step();
            chk($sformatf("t3_inc_e%0d", k), inc,
                (k == 7) || (k == 15) || (k >= 19 && k <= 35 && ((k - 19) % 4) == 0));
            if (k == 6) chk("t3_dir_before", up_down_sel, 1'b1);
            if (k == 7) chk("t3_dir_pulse", up_down_sel, 1'b0);
            if (k == 30) btn_up_raw = 1'b0;
        end
        repeat_en = 1'b0;
        settle(4);

        // 4: up held, down added -> lock; release up, still locked; release all
        btn_up_raw = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            chk($sformatf("t4_inc_e%0d", k), inc, (k == 7));
            chk($sformatf("t4_lock_e%0d", k), btn_lock, (k >= 16 && k < 37));
            if (k == 9)  btn_down_raw = 1'b1;
            if (k == 20) btn_up_raw   = 1'b0;
            if (k == 30) btn_down_raw = 1'b0;
        end
        btn_up_raw = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("t4b_inc_e%0d", k), inc, (k == 7));
            if (k == 7) chk("t4b_dir", up_down_sel, 1'b0);
        end
        btn_up_raw = 1'b0;
        settle(15);

        // 5: both buttons rise together -> lock at edge 7, no pulses
        btn_up_raw   = 1'b1;
        btn_down_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("t5_inc_e%0d", k), inc, 1'b0);
            chk($sformatf("t5_lock_e%0d", k), btn_lock, (k >= 7 && k < 17));
            if (k == 10) begin
                btn_up_raw   = 1'b0;
                btn_down_raw = 1'b0;
            end
        end
        settle(4);

        // 6: reset during repeat while up stays held
        repeat_en  = 1'b1;
        btn_up_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("t6_inc_e%0d", k), inc, (k == 7) || (k == 15) || (k == 19));
        end
        reset = 1'b1;
        step();
        chk("t6_rst_inc", inc, 1'b0);
        chk("t6_rst_dir", up_down_sel, 1'b0);
        chk("t6_rst_lock", btn_lock, 1'b0);
        reset = 1'b0;
        for (int m = 1; m <= 16; m++) begin
            step();
            chk($sformatf("t6b_inc_e%0d", m), inc, (m == 7) || (m == 15));
        end
        btn_up_raw = 1'b0;
        repeat_en  = 1'b0;
        settle(12);
        chk("end_inc", inc, 1'b0);
        chk("end_lock", btn_lock, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_count_pulse_gen
`default_nettype wire
